// File: rtl/seg7_pkg.sv
// Shared types and hex-to-segment table for the multiplexed seven-segment scan driver.
package seg7_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GUARD = 2'd1,
    SHOW  = 2'd2
  } state_e;

  // Active-high "no segments lit" pattern, {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_OFF = 7'h00;

  // Entry n occupies bits [7n+6:7n]; F is the most significant entry
  localparam logic [16*7-1:0] HEX_SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [6:0] hex2seg(input logic [3:0] nibble);
    return HEX_SEG_TABLE[7'(nibble) * 7'd7 +: 7];
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble to active-high {g,f,e,d,c,b,a} segment pattern.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_c
);

  assign seg_c = hex2seg(nibble);

endmodule

// File: rtl/seg7_scan_driver.sv
// Steps a multiplexed seven-segment display one digit per rising edge of a slow scan level.
// Optional leading-zero blanking is enabled by defining SEG7_LZ_BLANK_EN.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned DIGITS         = 4,
  parameter int unsigned GUARD_CYCLES   = 2,
  parameter int unsigned ACTIVE_LOW_SEG = 1,
  parameter int unsigned ACTIVE_LOW_AN  = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       scan_in,
  input  logic [4*DIGITS-1:0]        value,
  input  logic [DIGITS-1:0]          dp_en,
  input  logic                       blank,
  output logic [DIGITS-1:0]          an,
  output logic [6:0]                 seg,
  output logic                       dp,
  output logic [$clog2(DIGITS)-1:0]  digit_idx
);

  localparam int unsigned IDX_W      = $clog2(DIGITS);
  localparam int unsigned CNT_W      = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
  localparam int unsigned GUARD_LAST = (GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0;
  localparam state_e      POST_STEP  = (GUARD_CYCLES > 0) ? GUARD : SHOW;

  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [DIGITS-1:0] AN_OFF   = (ACTIVE_LOW_AN != 0) ? {DIGITS{1'b1}} : '0;
  localparam logic [6:0]        SEG_IDLE = (ACTIVE_LOW_SEG != 0) ? ~SEG_OFF : SEG_OFF;
  localparam logic              DP_OFF   = (ACTIVE_LOW_SEG != 0);

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d, idx_inc;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [4*DIGITS-1:0]   frame_val_q, frame_val_d;
  logic [DIGITS-1:0]     frame_dp_q, frame_dp_d;
  logic                  s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic [DIGITS-1:0]     an_q, an_d, an_act;
  logic [6:0]            seg_q, seg_d, seg_act;
  logic                  dp_q, dp_d, dp_act;
  logic                  step_c, show_c, lz_blank_c;
  logic [3:0]            nibble_c;
  logic [6:0]            dec_seg_c;

  // scan_in is a level from another domain: two-flop synchroniser plus history flop
  always_comb begin
    s1_d   = scan_in;
    s2_d   = s1_q;
    s3_d   = s2_q;
    step_c = s2_q & ~s3_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      frame_val_q <= '0;
      frame_dp_q  <= '0;
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      s3_q        <= 1'b0;
      an_q        <= AN_OFF;
      seg_q       <= SEG_IDLE;
      dp_q        <= DP_OFF;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      frame_val_q <= frame_val_d;
      frame_dp_q  <= frame_dp_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      s3_q        <= s3_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
    end
  end

  // Next state: every step advances idx, even mid-guard; wrapping to 0 latches a new frame
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    frame_val_d = frame_val_q;
    frame_dp_d  = frame_dp_q;
    idx_inc     = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    unique case (state_q)
      IDLE: begin
        if (step_c) begin
          idx_d       = '0;
          cnt_d       = '0;
          frame_val_d = value;
          frame_dp_d  = dp_en;
          state_d     = POST_STEP;
        end
      end
      GUARD, SHOW: begin
        if (step_c) begin
          idx_d   = idx_inc;
          cnt_d   = '0;
          state_d = POST_STEP;
          if (idx_inc == '0) begin
            frame_val_d = value;
            frame_dp_d  = dp_en;
          end
        end else if (state_q == GUARD) begin
          if (cnt_q == CNT_W'(GUARD_LAST)) begin
            cnt_d   = '0;
            state_d = SHOW;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign nibble_c = frame_val_q[{idx_q, 2'b00} +: 4];

  seg7_hex_decode u_hex_decode (
    .nibble (nibble_c),
    .seg_c  (dec_seg_c)
  );

`ifdef SEG7_LZ_BLANK_EN
  logic [IDX_W-1:0] msd_c;

  // Digits above the most significant non-zero nibble stay dark; digit 0 never blanks
  always_comb begin
    msd_c = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (frame_val_q[4*i +: 4] != 4'h0) msd_c = IDX_W'(i);
    end
    lz_blank_c = (idx_q > msd_c);
  end
`else
  assign lz_blank_c = 1'b0;
`endif

  always_comb begin
    show_c  = (state_q == SHOW) && !blank;
    an_act  = '0;
    seg_act = SEG_OFF;
    dp_act  = 1'b0;
    if (show_c) begin
      an_act  = DIGITS'(1) << idx_q;
      seg_act = lz_blank_c ? SEG_OFF : dec_seg_c;
      dp_act  = frame_dp_q[idx_q];
    end
    an_d  = (ACTIVE_LOW_AN != 0)  ? ~an_act  : an_act;
    seg_d = (ACTIVE_LOW_SEG != 0) ? ~seg_act : seg_act;
    dp_d  = (ACTIVE_LOW_SEG != 0) ? ~dp_act  : dp_act;
  end

  assign an        = an_q;
  assign seg       = seg_q;
  assign dp        = dp_q;
  assign digit_idx = idx_q;

endmodule
